// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath: instruction
// fields flow in, mux selects, strobes and extended-op qualifiers flow out.
interface multicycle_ctrl_if #(
  parameter int ALUCTRL_W = 4
);
  logic [1:0]           Op;
  logic [5:0]           Funct;
  logic [3:0]           Rd;
  logic                 CondEx;

  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemW;
  logic                 IRWrite;
  logic                 RegW;
  logic                 WrHi;
  logic [1:0]           ResultSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ImmSrc;
  logic [1:0]           RegSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic [1:0]           FlagW;
  logic                 Carry;
  logic                 NoWrite;
  logic                 Shift;
  logic                 Saturated;
  logic                 Negate;
  logic                 Unsigned;
  logic                 Long;
  logic                 Busy;

  // Controller side.
  modport master (
    input  Op, Funct, Rd, CondEx,
    output PCWrite, AdrSrc, MemW, IRWrite, RegW, WrHi, ResultSrc, ALUSrcA,
           ALUSrcB, ImmSrc, RegSrc, ALUControl, FlagW, Carry, NoWrite, Shift,
           Saturated, Negate, Unsigned, Long, Busy
  );

  // Datapath side.
  modport slave (
    output Op, Funct, Rd, CondEx,
    input  PCWrite, AdrSrc, MemW, IRWrite, RegW, WrHi, ResultSrc, ALUSrcA,
           ALUSrcB, ImmSrc, RegSrc, ALUControl, FlagW, Carry, NoWrite, Shift,
           Saturated, Negate, Unsigned, Long, Busy
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM controller: sequences each instruction through an FSM with
// registered Moore outputs, extended decode and iterative multiply/divide.
module multicycle_ctrl #(
  parameter int ALUCTRL_W = 4,
  parameter int MUL_CYC   = 2,
  parameter int DIV_CYC   = 32,
  parameter int LONG_EN   = 1
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI,
    ALUWB, MULEX, DIVEX, LWBLO, LWBHI, BRANCH
  } state_t;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_ORR   = 4'b0011;
  localparam logic [3:0] ALU_EOR   = 4'b0100;
  localparam logic [3:0] ALU_RSB   = 4'b0101;
  localparam logic [3:0] ALU_MUL   = 4'b0110;
  localparam logic [3:0] ALU_MLA   = 4'b0111;
  localparam logic [3:0] ALU_DIV   = 4'b1000;
  localparam logic [3:0] ALU_PASSB = 4'b1001;

  typedef struct packed {
    logic [3:0] alu;
    logic       carry;
    logic       no_write;
    logic       shift;
    logic       sat;
    logic       negate;
    logic       uns;
    logic       long_op;
    logic       logic_op;
    logic       div;
    logic       undef;
  } dec_t;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_w;
    logic       ir_write;
    logic       reg_w;
    logic       wr_hi;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] flag_w;
    logic [3:0] alu;
    logic       busy;
    logic       cond_gate;
  } ctl_t;

  state_t     state, state_nxt;
  ctl_t       ctl_q;
  dec_t       dec;
  logic [5:0] cnt;
  logic [3:0] fn;
  logic       s_bit;
  logic       rd_pc;
  logic       live;
  logic       cond_ok;

  assign fn    = bus.Funct[4:1];
  assign s_bit = bus.Funct[0];
  assign rd_pc = (bus.Rd == 4'd15);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    dec     = '0;
    dec.alu = ALU_ADD;
    case (bus.Op)
      2'b00: begin
        case (fn)
          4'b0000: dec.alu = ALU_AND;
          4'b0001: dec.alu = ALU_EOR;
          4'b0010: dec.alu = ALU_SUB;
          4'b0011: dec.alu = ALU_RSB;
          4'b0100: dec.alu = ALU_ADD;
          4'b0101: dec.alu = ALU_ADD;
          4'b0110: dec.alu = ALU_SUB;
          4'b0111: dec.alu = ALU_RSB;
          4'b1000: begin
            dec.alu      = s_bit ? ALU_AND : ALU_ADD;
            dec.no_write = s_bit;
            dec.sat      = ~s_bit;
          end
          4'b1001: begin
            dec.alu      = s_bit ? ALU_EOR : ALU_SUB;
            dec.no_write = s_bit;
            dec.sat      = ~s_bit;
          end
          4'b1010: begin
            dec.alu      = ALU_SUB;
            dec.no_write = 1'b1;
          end
          4'b1011: begin
            dec.alu      = ALU_ADD;
            dec.no_write = 1'b1;
          end
          4'b1100: dec.alu = ALU_ORR;
          4'b1101: begin
            dec.alu   = ALU_PASSB;
            dec.shift = 1'b1;
          end
          4'b1110: begin
            dec.alu    = ALU_AND;
            dec.negate = 1'b1;
          end
          default: begin
            dec.alu    = ALU_ORR;
            dec.negate = 1'b1;
          end
        endcase
        dec.carry    = fn inside {4'b0101, 4'b0110, 4'b0111};
        // Logical ops leave C/V alone when S is set.
        dec.logic_op = dec.alu inside {ALU_AND, ALU_ORR, ALU_EOR, ALU_PASSB};
      end
      2'b11: begin
        case (fn)
          4'b0000: dec.alu = ALU_MUL;
          4'b0001: dec.alu = ALU_MLA;
          4'b0011, 4'b0101: begin
            dec.alu     = ALU_MUL;
            dec.long_op = (LONG_EN != 0);
            dec.uns     = (fn == 4'b0011);
          end
          4'b0100, 4'b0110: begin
            dec.alu     = ALU_MLA;
            dec.long_op = (LONG_EN != 0);
            dec.uns     = (fn == 4'b0100);
          end
          4'b0010, 4'b0111, 4'b1000: begin
            dec.alu = ALU_DIV;
            dec.div = 1'b1;
            dec.uns = (fn == 4'b0111);
          end
          default: begin
            dec.alu   = 4'b0000;
            dec.undef = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

  function automatic ctl_t ctl_for(state_t s, dec_t d, logic sb, logic to_pc);
    ctl_t c;
    c           = '0;
    c.alu       = d.alu;
    c.cond_gate = 1'b1;
    case (s)
      FETCH: begin
        c.ir_write   = 1'b1;
        c.pc_write   = 1'b1;
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.alu        = ALU_ADD;
        c.cond_gate  = 1'b0;
      end
      DECODE: begin
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.alu        = ALU_ADD;
        c.cond_gate  = 1'b0;
      end
      MEMADR: c.alu_src_b = 2'b01;
      MEMRD:  c.adr_src   = 1'b1;
      MEMWB: begin
        c.result_src = 2'b01;
        c.reg_w      = 1'b1;
      end
      MEMWR: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      EXECR: c.alu_src_b = 2'b00;
      EXECI: c.alu_src_b = 2'b01;
      ALUWB: begin
        c.reg_w    = ~d.no_write & ~d.undef;
        c.flag_w   = {sb, sb & ~d.logic_op};
        c.pc_write = c.reg_w & to_pc;
      end
      MULEX, DIVEX: c.busy = 1'b1;
      LWBLO: c.reg_w = 1'b1;
      LWBHI: begin
        c.reg_w = 1'b1;
        c.wr_hi = 1'b1;
      end
      BRANCH: begin
        c.alu_src_b  = 2'b01;
        c.result_src = 2'b10;
        c.pc_write   = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        if (dec.undef)            state_nxt = FETCH;
        else if (bus.Op == 2'b01) state_nxt = MEMADR;
        else if (bus.Op == 2'b10) state_nxt = BRANCH;
        else if (bus.Op == 2'b00) state_nxt = bus.Funct[5] ? EXECI : EXECR;
        else                      state_nxt = dec.div ? DIVEX : MULEX;
      end
      MEMADR: state_nxt = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_nxt = MEMWB;
      EXECR, EXECI: state_nxt = ALUWB;
      MULEX: if (cnt == 6'(MUL_CYC - 1)) state_nxt = dec.long_op ? LWBLO : ALUWB;
      DIVEX: if (cnt == 6'(DIV_CYC - 1)) state_nxt = dec.long_op ? LWBLO : ALUWB;
      LWBLO:  state_nxt = LWBHI;
      default: state_nxt = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ctl_q <= ctl_for(FETCH, dec, s_bit, rd_pc);
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ctl_q <= ctl_for(state_nxt, dec, s_bit, rd_pc);
      // Iteration counter runs only while an execute state repeats.
      if (state_nxt == state && (state == MULEX || state == DIVEX))
        cnt <= cnt + 6'd1;
      else
        cnt <= '0;
    end
  end

  // Strobes are silenced during reset and, outside FETCH/DECODE, by a failed condition.
  assign live    = ~reset;
  assign cond_ok = ~ctl_q.cond_gate | bus.CondEx;

  assign bus.PCWrite    = ctl_q.pc_write & live & cond_ok;
  assign bus.MemW       = ctl_q.mem_w & live & cond_ok;
  assign bus.RegW       = ctl_q.reg_w & live & cond_ok;
  assign bus.FlagW      = ctl_q.flag_w & {2{live & cond_ok}};
  assign bus.IRWrite    = ctl_q.ir_write & live;
  assign bus.Busy       = ctl_q.busy & live;
  assign bus.AdrSrc     = ctl_q.adr_src;
  assign bus.WrHi       = ctl_q.wr_hi;
  assign bus.ResultSrc  = ctl_q.result_src;
  assign bus.ALUSrcA    = ctl_q.alu_src_a;
  assign bus.ALUSrcB    = ctl_q.alu_src_b;
  assign bus.ALUControl = ALUCTRL_W'(ctl_q.alu);
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};

  assign bus.Carry     = dec.carry;
  assign bus.NoWrite   = dec.no_write;
  assign bus.Shift     = dec.shift;
  assign bus.Saturated = dec.sat;
  assign bus.Negate    = dec.negate;
  assign bus.Unsigned  = dec.uns;
  assign bus.Long      = dec.long_op;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a per-instruction cycle-sequence model built from
// the instruction class checks every cycle of directed and random programs.
module tb_multicycle_ctrl;

  localparam int W       = 4;
  localparam int MUL_CYC = 2;
  localparam int DIV_CYC = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.ALUCTRL_W(W)) bus ();
  multicycle_ctrl_if #(.ALUCTRL_W(W)) bus_nl ();

  multicycle_ctrl #(.ALUCTRL_W(W), .MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC), .LONG_EN(1))
    dut (.clk(clk), .reset(reset), .bus(bus.master));
  multicycle_ctrl #(.ALUCTRL_W(W), .MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC), .LONG_EN(0))
    dut_nl (.clk(clk), .reset(reset), .bus(bus_nl.master));

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       mem_w;
    logic       reg_w;
    logic [1:0] flag_w;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu;
    logic       busy;
    logic       wr_hi;
  } ctl_t;

  typedef struct {
    ctl_t c;
    bit   chk_alu;
    bit   chk_q;
    int   ph;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic string pname(input int p);
    case (p)
      0: return "FETCH";   1: return "DECODE"; 2: return "MEMADR";  3: return "MEMRD";
      4: return "MEMWB";   5: return "MEMWR";  6: return "EXEC";    7: return "ALUWB";
      8: return "MULEX";   9: return "DIVEX";  10: return "LWBLO";  11: return "LWBHI";
      default: return "BRANCH";
    endcase
  endfunction

  function automatic beat_t mk(input int p, input logic [3:0] alu);
    beat_t b;
    b.c       = '0;
    b.c.alu   = alu;
    b.chk_alu = 1'b1;
    b.chk_q   = 1'b1;
    b.ph      = p;
    return b;
  endfunction

  // Expected cycle-by-cycle outputs of one instruction. q = {Carry, NoWrite,
  // Shift, Saturated, Negate, Unsigned, Long}.
  task automatic build(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                       input logic cond, input bit long_en, output logic [6:0] q);
    logic [3:0] f, alu;
    logic s;
    bit logical, undef, isdiv, islong, nowrite;
    beat_t b;
    f = fn[4:1]; s = fn[0]; alu = 4'd0;
    logical = 0; undef = 0; isdiv = 0; islong = 0; nowrite = 0; q = '0;
    exp_q.delete();
    if (op == 2'b00) begin
      case (f)
        4'd4, 4'd5, 4'd11: alu = 4'd0;
        4'd2, 4'd6, 4'd10: alu = 4'd1;
        4'd0, 4'd14:       alu = 4'd2;
        4'd12, 4'd15:      alu = 4'd3;
        4'd1:              alu = 4'd4;
        4'd3, 4'd7:        alu = 4'd5;
        4'd13:             alu = 4'd9;
        4'd8:              alu = s ? 4'd2 : 4'd0;
        default:           alu = s ? 4'd4 : 4'd1;
      endcase
      nowrite = ((f inside {4'd8, 4'd9}) && s) || (f inside {4'd10, 4'd11});
      logical = (f inside {4'd0, 4'd1, 4'd12, 4'd13, 4'd14, 4'd15}) || ((f inside {4'd8, 4'd9}) && s);
      q = {f inside {4'd5, 4'd6, 4'd7}, nowrite, f == 4'd13,
           (f inside {4'd8, 4'd9}) && !s, f inside {4'd14, 4'd15}, 1'b0, 1'b0};
    end else if (op == 2'b11) begin
      if (f inside {4'd2, 4'd7, 4'd8}) begin
        isdiv = 1; alu = 4'd8; q[1] = (f == 4'd7);
      end else if (f inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6}) begin
        alu    = (f inside {4'd1, 4'd4, 4'd6}) ? 4'd7 : 4'd6;
        islong = long_en && (f inside {4'd3, 4'd4, 4'd5, 4'd6});
        q[1]   = f inside {4'd3, 4'd4};
        q[0]   = islong;
      end else begin
        undef = 1;
      end
    end

    b = mk(0, 4'd0);
    b.c.ir_write = 1; b.c.pc_write = 1; b.c.alu_src_a = 2'b01; b.c.alu_src_b = 2'b10;
    b.c.result_src = 2'b10; b.chk_q = 0;
    exp_q.push_back(b);
    b = mk(1, alu);
    b.c.alu_src_a = 2'b01; b.c.alu_src_b = 2'b10; b.c.result_src = 2'b10; b.chk_alu = 0;
    exp_q.push_back(b);

    if (op == 2'b01) begin
      b = mk(2, 4'd0); b.c.alu_src_b = 2'b01; exp_q.push_back(b);
      if (fn[0]) begin
        b = mk(3, 4'd0); b.c.adr_src = 1; b.chk_alu = 0; exp_q.push_back(b);
        b = mk(4, 4'd0); b.c.result_src = 2'b01; b.c.reg_w = cond; b.chk_alu = 0; exp_q.push_back(b);
      end else begin
        b = mk(5, 4'd0); b.c.adr_src = 1; b.c.mem_w = cond; b.chk_alu = 0; exp_q.push_back(b);
      end
    end else if (op == 2'b10) begin
      b = mk(12, 4'd0); b.c.alu_src_b = 2'b01; b.c.result_src = 2'b10; b.c.pc_write = cond;
      b.chk_alu = 0; exp_q.push_back(b);
    end else if (!undef) begin
      if (op == 2'b00) begin
        b = mk(6, alu); b.c.alu_src_b = fn[5] ? 2'b01 : 2'b00; exp_q.push_back(b);
      end else begin
        for (int i = 0; i < (isdiv ? DIV_CYC : MUL_CYC); i++) begin
          b = mk(isdiv ? 9 : 8, alu); b.c.busy = 1; exp_q.push_back(b);
        end
      end
      if (islong) begin
        b = mk(10, alu); b.c.reg_w = cond; exp_q.push_back(b);
        b = mk(11, alu); b.c.reg_w = cond; b.c.wr_hi = 1; exp_q.push_back(b);
      end else begin
        b = mk(7, alu);
        b.c.reg_w    = cond && !nowrite;
        b.c.flag_w   = cond ? {s, s && !logical} : 2'b00;
        b.c.pc_write = cond && !nowrite && (rd == 4'd15);
        exp_q.push_back(b);
      end
    end
  endtask

  function automatic ctl_t sample_ctl(input bit nl);
    if (nl)
      return {bus_nl.IRWrite, bus_nl.PCWrite, bus_nl.MemW, bus_nl.RegW, bus_nl.FlagW,
              bus_nl.AdrSrc, bus_nl.ResultSrc, bus_nl.ALUSrcA, bus_nl.ALUSrcB,
              bus_nl.ALUControl, bus_nl.Busy, bus_nl.WrHi};
    return {bus.IRWrite, bus.PCWrite, bus.MemW, bus.RegW, bus.FlagW, bus.AdrSrc,
            bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.Busy, bus.WrHi};
  endfunction

  function automatic logic [6:0] sample_q(input bit nl);
    if (nl)
      return {bus_nl.Carry, bus_nl.NoWrite, bus_nl.Shift, bus_nl.Saturated,
              bus_nl.Negate, bus_nl.Unsigned, bus_nl.Long};
    return {bus.Carry, bus.NoWrite, bus.Shift, bus.Saturated, bus.Negate,
            bus.Unsigned, bus.Long};
  endfunction

  function automatic logic [6:0] strobes();
    return {bus.PCWrite, bus.MemW, bus.IRWrite, bus.RegW, bus.FlagW, bus.Busy};
  endfunction

  task automatic drive(input bit nl, input logic [1:0] op, input logic [5:0] fn,
                       input logic [3:0] rd, input logic cond);
    if (nl) begin
      bus_nl.Op = op; bus_nl.Funct = fn; bus_nl.Rd = rd; bus_nl.CondEx = cond;
    end else begin
      bus.Op = op; bus.Funct = fn; bus.Rd = rd; bus.CondEx = cond;
    end
  endtask

  // Entered and left with the DUT in FETCH, just after a rising edge.
  task automatic run_instr(input bit nl, input string tag, input logic [1:0] op,
                           input logic [5:0] fn, input logic [3:0] rd, input logic cond);
    logic [6:0] eq, gq;
    ctl_t got, want;
    build(op, fn, rd, cond, !nl, eq);
    drive(nl, op, fn, rd, cond);
    #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      got  = sample_ctl(nl);
      want = exp_q[i].c;
      if (!exp_q[i].chk_alu) begin
        got.alu  = '0;
        want.alu = '0;
      end
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s %s cycle %0d: ctl got %b expected %b", tag, pname(exp_q[i].ph), i, got, want);
      end
      if (exp_q[i].chk_q) begin
        gq = sample_q(nl);
        checks++;
        if (gq !== eq) begin
          errors++;
          $display("FAIL %s %s cycle %0d qualifiers: got %b expected %b", tag, pname(exp_q[i].ph), i, gq, eq);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (strobes() !== 7'b0) begin
      errors++;
      $display("FAIL power-up reset strobes: got %b expected 0000000", strobes());
    end
    reset = 1'b0;
    drive(0, 2'b11, 6'b010000, 4'd2, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL reset setup busy in DIVEX: got %b expected 1", bus.Busy);
    end
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      checks++;
      if (strobes() !== 7'b0) begin
        errors++;
        $display("FAIL reset mid-DIVEX strobes cycle %0d: got %b expected 0000000", i, strobes());
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.IRWrite, bus.PCWrite, bus.Busy, bus.RegW} !== 4'b1100) begin
      errors++;
      $display("FAIL reset release FETCH: got IRWrite/PCWrite/Busy/RegW %b expected 1100",
               {bus.IRWrite, bus.PCWrite, bus.Busy, bus.RegW});
    end
  endtask

  task automatic test_alu();
    run_instr(0, "ADDS", 2'b00, 6'b001001, 4'd1, 1'b1);
    run_instr(0, "CMP", 2'b00, 6'b010101, 4'd0, 1'b1);
    run_instr(0, "CMP_nocond", 2'b00, 6'b010101, 4'd0, 1'b0);
    run_instr(0, "ANDS_imm", 2'b00, 6'b100001, 4'd3, 1'b1);
    run_instr(0, "MOV_pc", 2'b00, 6'b111010, 4'd15, 1'b1);
    run_instr(0, "QADD", 2'b00, 6'b010000, 4'd4, 1'b1);
  endtask

  task automatic test_mem();
    run_instr(0, "LDR", 2'b01, 6'b011001, 4'd5, 1'b1);
    run_instr(0, "STR", 2'b01, 6'b011000, 4'd5, 1'b1);
    run_instr(0, "B", 2'b10, 6'b100000, 4'd0, 1'b1);
  endtask

  task automatic test_muldiv();
    run_instr(0, "UMULL", 2'b11, 6'b000110, 4'd6, 1'b1);
    run_instr(0, "SDIV", 2'b11, 6'b010000, 4'd7, 1'b1);
    run_instr(0, "UDIV_nocond", 2'b11, 6'b001110, 4'd7, 1'b0);
    run_instr(0, "UNDEF", 2'b11, 6'b011110, 4'd7, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] rd;
    logic       cond;
    for (int n = 0; n < 300; n++) begin
      op   = 2'($urandom_range(0, 3));
      fn   = 6'($urandom);
      rd   = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      cond = ($urandom_range(0, 3) != 0);
      run_instr(0, "random", op, fn, rd, cond);
    end
  endtask

  task automatic test_long_disabled();
    reset_pulse();
    run_instr(1, "UMULL_nolong", 2'b11, 6'b000110, 4'd6, 1'b1);
    run_instr(1, "SMLAL_nolong", 2'b11, 6'b001101, 4'd6, 1'b1);
    for (int n = 0; n < 20; n++)
      run_instr(1, "random_nolong", 2'b11, 6'($urandom), 4'($urandom), 1'($urandom));
  endtask

  initial begin
    drive(0, 2'b00, 6'b0, 4'd0, 1'b1);
    drive(1, 2'b00, 6'b0, 4'd0, 1'b1);
    test_reset();
    test_alu();
    test_mem();
    test_muldiv();
    test_back_to_back();
    test_long_disabled();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
